// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_streamer
//  Purpose  : Walks a width x height frame held in an external frame memory,
//             presents each pixel downstream with hsync/vsync markers and
//             writes the downstream result back to the same pixel address
//             LATENCY enabled cycles after the pixel was consumed.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1           rising-edge clock
//    reset_n  in   1           synchronous active-low reset
//    en       in   1           global advance, 0 freezes the block
//    start    in   1           frame start request (ignored while busy)
//    width    in   DIM_WIDTH   pixels per row, sampled at start
//    height   in   DIM_WIDTH   rows per frame, sampled at start
//    rd_en    out  1           frame-memory read strobe
//    rd_addr  out  ADDR_WIDTH  pixel index to read
//    rd_data  in   PIXEL_SIZE  read data, captured on the edge ending rd_en
//    data     out  PIXEL_SIZE  pixel presented downstream
//    valid    out  1           data holds a pixel
//    hsync    out  1           presented pixel is in column 0
//    vsync    out  1           presented pixel is index 0
//    result   in   PIXEL_SIZE  downstream result for the pixel consumed
//                              LATENCY enabled cycles earlier
//    wr_en    out  1           write-back strobe
//    wr_addr  out  ADDR_WIDTH  write-back pixel index
//    wr_data  out  PIXEL_SIZE  result while writing, 0 otherwise
//    busy     out  1           frame in progress
//    done     out  1           one-cycle frame-complete pulse
// ============================================================================
module frame_streamer #(
  parameter int PIXEL_SIZE = 24,
  parameter int DIM_WIDTH  = 10,
  parameter int ADDR_WIDTH = 20,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  valid,
  output logic                  hsync,
  output logic                  vsync,
  input  logic [PIXEL_SIZE-1:0] result,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_SIZE-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  generate
    if (ADDR_WIDTH < 2 * DIM_WIDTH) begin : g_bad_addr_width
      $error("frame_streamer: ADDR_WIDTH must be >= 2*DIM_WIDTH");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("frame_streamer: LATENCY must be in 0..15");
    end
  endgenerate

  localparam bit c_NO_PIPE = (LATENCY == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [DIM_WIDTH-1:0]  r_width;
  logic [ADDR_WIDTH-1:0] r_total;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic [DIM_WIDTH-1:0]  r_rd_col;
  logic [ADDR_WIDTH-1:0] r_cons_cnt;
  logic [PIXEL_SIZE-1:0] r_data;
  logic                  r_valid;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_rd_en;
  logic                  w_consume;
  logic                  w_last_consume;
  logic [ADDR_WIDTH-1:0] w_total_calc;
  logic                  w_dl_out_vld;
  logic [ADDR_WIDTH-1:0] w_dl_out_addr;
  logic                  w_dl_next_empty;

  assign w_total_calc   = ADDR_WIDTH'(width) * ADDR_WIDTH'(height);
  // The last term is redundant while en gates the strobe, but keeps a
  // frozen capture register from being overwritten if that gating changes.
  assign w_rd_en        = (r_state == S_STREAM) && en && (r_rd_cnt < r_total)
                          && !(r_valid && !en);
  assign w_consume      = r_valid && en;
  assign w_last_consume = w_consume && (r_cons_cnt == r_total - ADDR_WIDTH'(1));

  // --------------------------------------------------------------------------
  // Control FSM and frame counters; everything here freezes while en=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_total    <= '0;
      r_rd_cnt   <= '0;
      r_rd_col   <= '0;
      r_cons_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (en) begin
      r_done <= 1'b0;
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
        r_rd_col <= (r_rd_col == r_width - DIM_WIDTH'(1)) ? '0
                                                           : r_rd_col + DIM_WIDTH'(1);
      end
      if (w_consume) begin
        r_cons_cnt <= r_cons_cnt + ADDR_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (width != '0 && height != '0) begin
              r_width    <= width;
              r_total    <= w_total_calc;
              r_rd_cnt   <= '0;
              r_rd_col   <= '0;
              r_cons_cnt <= '0;
              r_state    <= S_STREAM;
            end else begin
              // Empty frame: report completion without touching memory.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_STREAM: begin
          if (w_last_consume) begin
            // With no pipeline the final write happens in this very cycle,
            // so there is nothing left to drain.
            if (c_NO_PIPE) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_dl_next_empty) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Capture register. A read issued in a cycle always lands on the next edge,
  // so the pixel is never lost even if en drops right afterwards.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else if (w_rd_en) begin
      r_data  <= rd_data;
      r_valid <= 1'b1;
      r_hsync <= (r_rd_col == '0);
      r_vsync <= (r_rd_cnt == '0);
    end else if (w_consume) begin
      r_valid <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back delay line: one slot per downstream pipeline stage, carrying
  // the consumed pixel index so the result lands at the right address.
  // --------------------------------------------------------------------------
  generate
    if (LATENCY == 0) begin : g_lat0
      assign w_dl_out_vld    = w_consume;
      assign w_dl_out_addr   = r_cons_cnt;
      assign w_dl_next_empty = 1'b1;
    end else begin : g_latn
      logic                  r_dl_vld  [LATENCY];
      logic [ADDR_WIDTH-1:0] r_dl_addr [LATENCY];
      logic                  w_upstream_any;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_dl_vld[i]  <= 1'b0;
            r_dl_addr[i] <= '0;
          end
        end else if (en) begin
          r_dl_vld[0]  <= w_consume;
          r_dl_addr[0] <= w_consume ? r_cons_cnt : '0;
          for (int i = 1; i < LATENCY; i++) begin
            r_dl_vld[i]  <= r_dl_vld[i-1];
            r_dl_addr[i] <= r_dl_addr[i-1];
          end
        end
      end

      // Valid entries that will still be inside the line after this edge.
      always_comb begin
        w_upstream_any = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
          w_upstream_any = w_upstream_any | r_dl_vld[i];
        end
      end

      assign w_dl_next_empty = en ? !(w_consume || w_upstream_any)
                                  : !(w_upstream_any || r_dl_vld[LATENCY-1]);
      assign w_dl_out_vld    = r_dl_vld[LATENCY-1];
      assign w_dl_out_addr   = r_dl_addr[LATENCY-1];
    end
  endgenerate

  assign rd_en   = w_rd_en;
  assign rd_addr = r_rd_cnt;
  assign data    = r_data;
  assign valid   = r_valid;
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign wr_en   = en && w_dl_out_vld;
  assign wr_addr = w_dl_out_addr;
  // Held at 0 outside write cycles so idle and reset leave every output low.
  assign wr_data = wr_en ? result : '0;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_frame_streamer
//  Purpose  : Directed self-checking bench for frame_streamer, with one
//             instance at LATENCY=2 and one at LATENCY=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;
  localparam int PW = 24;
  localparam int DW = 10;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, en, start, start0;
  logic [DW-1:0] width, height;

  // LATENCY=2 instance
  logic          rd_en, valid, hsync, vsync, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] rd_data, data, result, wr_data;
  // LATENCY=0 instance
  logic          z_rd_en, z_valid, z_hsync, z_vsync, z_wr_en, z_busy, z_done;
  logic [AW-1:0] z_rd_addr, z_wr_addr;
  logic [PW-1:0] z_rd_data, z_data, z_wr_data;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [PW-1:0] pix(input int a);
    return 24'hA50000 ^ PW'(a);
  endfunction

  // Frame memory contents are a fixed function of the address.
  assign rd_data   = pix(int'(rd_addr));
  assign z_rd_data = pix(int'(z_rd_addr));
  // Downstream result changes every cycle so a stale/misrouted value shows.
  always @(posedge clk) cyc <= cyc + 1;
  assign result = 24'h5A0000 | PW'(cyc & 16'hFFFF);

  frame_streamer #(.PIXEL_SIZE(PW), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start),
    .width(width), .height(height),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data(data), .valid(valid), .hsync(hsync), .vsync(vsync),
    .result(result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  frame_streamer #(.PIXEL_SIZE(PW), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start0),
    .width(width), .height(height),
    .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .data(z_data), .valid(z_valid), .hsync(z_hsync), .vsync(z_vsync),
    .result(result), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .busy(z_busy), .done(z_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected LATENCY=2 outputs for a 4x2 frame: e is the frame step whose
  // registered state is visible, frz marks a cycle with en=0.
  task automatic chk_frame(input string sc, input int c, input int e, input bit frz);
    bit e_rd, e_vld, e_wr;
    e_rd  = !frz && e >= 1 && e <= 8;
    e_vld = e >= 2 && e <= 9;
    e_wr  = !frz && e >= 4 && e <= 11;
    chk($sformatf("%s c%0d rd_en", sc, c), 32'(rd_en), 32'(e_rd));
    if (e_rd) chk($sformatf("%s c%0d rd_addr", sc, c), 32'(rd_addr), 32'(e - 1));
    chk($sformatf("%s c%0d valid", sc, c), 32'(valid), 32'(e_vld));
    if (e_vld) chk($sformatf("%s c%0d data", sc, c), 32'(data), 32'(pix(e - 2)));
    chk($sformatf("%s c%0d hsync", sc, c), 32'(hsync), 32'(e_vld && ((e - 2) % 4 == 0)));
    chk($sformatf("%s c%0d vsync", sc, c), 32'(vsync), 32'(e_vld && e == 2));
    chk($sformatf("%s c%0d wr_en", sc, c), 32'(wr_en), 32'(e_wr));
    if (e_wr) chk($sformatf("%s c%0d wr_addr", sc, c), 32'(wr_addr), 32'(e - 4));
    chk($sformatf("%s c%0d wr_data", sc, c), 32'(wr_data), e_wr ? 32'(result) : 32'd0);
    chk($sformatf("%s c%0d done", sc, c), 32'(done), 32'(e == 12));
    chk($sformatf("%s c%0d busy", sc, c), 32'(busy), 32'(e >= 1 && e <= 12));
  endtask

  // Plain 4x2 frame with en=1, start in cycle 0; also checks write coverage.
  task automatic run_plain(input string sc);
    int wmask, wcnt;
    wmask = 0;
    wcnt  = 0;
    for (int c = 0; c <= 14; c++) begin
      next_cycle();
      start  = (c == 0);
      width  = 4;
      height = 2;
      #1;
      chk_frame(sc, c, c, 1'b0);
      if (wr_en) begin
        wcnt++;
        if (wr_addr < 32) wmask = wmask | (1 << wr_addr);
      end
    end
    chk({sc, " write count"}, 32'(wcnt), 32'd8);
    chk({sc, " write set"}, 32'(wmask), 32'hFF);
  endtask

  initial begin
    int wmask, wcnt, ndone, e;
    bit frz;
    reset_n = 1'b0; en = 1'b1; start = 1'b0; start0 = 1'b0; width = '0; height = '0;
    repeat (3) next_cycle();
    reset_n = 1'b1;
    #1;
    chk("reset busy",  32'(busy),  32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset rd_en", 32'(rd_en), 32'd0);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset done",  32'(done),  32'd0);
    chk("reset data",  32'(data),  32'd0);

    // 4x2 frame, en held high.
    run_plain("A");

    // Same frame with en=0 in cycles 5..9.
    wmask = 0; wcnt = 0;
    for (int c = 0; c <= 19; c++) begin
      next_cycle();
      start  = (c == 0);
      width  = 4;
      height = 2;
      en     = !(c >= 5 && c <= 9);
      frz    = !en;
      e      = (c <= 4) ? c : ((c <= 9) ? 5 : c - 5);
      #1;
      chk_frame("B", c, e, frz);
      if (wr_en) begin
        wcnt++;
        if (wr_addr < 32) wmask = wmask | (1 << wr_addr);
      end
    end
    en = 1'b1;
    chk("B write count", 32'(wcnt), 32'd8);
    chk("B write set", 32'(wmask), 32'hFF);

    // Zero width: done one cycle after start, no memory traffic.
    for (int c = 0; c <= 3; c++) begin
      next_cycle();
      start  = (c == 0);
      width  = 0;
      height = 2;
      #1;
      chk($sformatf("C c%0d rd_en", c), 32'(rd_en), 32'd0);
      chk($sformatf("C c%0d wr_en", c), 32'(wr_en), 32'd0);
      chk($sformatf("C c%0d done", c), 32'(done), 32'(c == 1));
      chk($sformatf("C c%0d busy", c), 32'(busy), 32'(c == 1));
    end

    // Second start (with other dimensions) mid-frame must be ignored.
    wcnt = 0; ndone = 0;
    for (int c = 0; c <= 16; c++) begin
      next_cycle();
      start  = (c == 0) || (c == 3);
      width  = (c == 3) ? 10'd2 : 10'd4;
      height = (c == 3) ? 10'd1 : 10'd2;
      #1;
      chk_frame("D", c, c, 1'b0);
      if (wr_en) wcnt++;
      if (done) ndone++;
    end
    chk("D write count", 32'(wcnt), 32'd8);
    chk("D done count", 32'(ndone), 32'd1);

    // Reset pulse in cycle 6 of a running frame.
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      start   = (c == 0);
      width   = 4;
      height  = 2;
      reset_n = (c != 6);
      #1;
      if (c <= 5) begin
        chk_frame("E", c, c, 1'b0);
      end else if (c >= 7) begin
        chk($sformatf("E c%0d rd_en", c),   32'(rd_en),   32'd0);
        chk($sformatf("E c%0d rd_addr", c), 32'(rd_addr), 32'd0);
        chk($sformatf("E c%0d data", c),    32'(data),    32'd0);
        chk($sformatf("E c%0d valid", c),   32'(valid),   32'd0);
        chk($sformatf("E c%0d hsync", c),   32'(hsync),   32'd0);
        chk($sformatf("E c%0d vsync", c),   32'(vsync),   32'd0);
        chk($sformatf("E c%0d wr_en", c),   32'(wr_en),   32'd0);
        chk($sformatf("E c%0d wr_addr", c), 32'(wr_addr), 32'd0);
        chk($sformatf("E c%0d wr_data", c), 32'(wr_data), 32'd0);
        chk($sformatf("E c%0d busy", c),    32'(busy),    32'd0);
        chk($sformatf("E c%0d done", c),    32'(done),    32'd0);
      end
    end
    reset_n = 1'b1;
    run_plain("E2");

    // LATENCY=0 instance, 2x2 frame: write lands in the consume cycle.
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      start0 = (c == 0);
      width  = 2;
      height = 2;
      #1;
      chk($sformatf("F c%0d rd_en", c), 32'(z_rd_en), 32'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk($sformatf("F c%0d rd_addr", c), 32'(z_rd_addr), 32'(c - 1));
      chk($sformatf("F c%0d valid", c), 32'(z_valid), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk($sformatf("F c%0d data", c), 32'(z_data), 32'(pix(c - 2)));
      chk($sformatf("F c%0d hsync", c), 32'(z_hsync), 32'(c == 2 || c == 4));
      chk($sformatf("F c%0d vsync", c), 32'(z_vsync), 32'(c == 2));
      chk($sformatf("F c%0d wr_en", c), 32'(z_wr_en), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk($sformatf("F c%0d wr_addr", c), 32'(z_wr_addr), 32'(c - 2));
        chk($sformatf("F c%0d wr_data", c), 32'(z_wr_data), 32'(result));
      end
      chk($sformatf("F c%0d done", c), 32'(z_done), 32'(c == 6));
      chk($sformatf("F c%0d busy", c), 32'(z_busy), 32'(c >= 1 && c <= 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
